pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Generates freeze/flush for PC, IF/ID, ID/EX (the stage register carrying WB_EN…dest, src1/src2), EX/MEM and MEM/WB.
- Resolves data hazards (with or without forwarding), taken-branch squash and multi-cycle data-memory waits via a ready handshake.
- Keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage ARM pipeline.
// Resolves data hazards, taken-branch squash and data-memory waits. It also
// keeps saturating performance counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_freeze,
    output logic             id_ex_flush,
    output logic             ex_mem_freeze,
    output logic             mem_wb_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              hazard;
    logic              exe_match;
    logic              mem_match;
    logic              take_branch;
    logic              take_hazard;

    // Source-operand matches against the EXE and MEM destinations, and the hazard decision
    always_comb begin
        exe_match = (id_use_src1 && (id_src1 == exe_dest)) ||
                    (id_two_src  && (id_src2 == exe_dest));
        mem_match = (id_use_src1 && (id_src1 == mem_dest)) ||
                    (id_two_src  && (id_src2 == mem_dest));
        if (fwd_en)
            hazard = exe_mem_r_en && exe_wb_en && exe_match;
        else
            hazard = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    // Next-state and prioritised freeze/flush outputs (mem_stall > branch > hazard)
    always_comb begin
        state_next    = state;
        mem_stall     = 1'b0;
        take_branch   = 1'b0;
        take_hazard   = 1'b0;
        pc_freeze     = 1'b0;
        if_id_freeze  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_freeze  = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_freeze = 1'b0;
        mem_wb_freeze = 1'b0;

        case (state)
            RUN: begin
                mem_stall = mem_req && !mem_ready;
                if (mem_stall)
                    state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                mem_stall = !mem_ready;
                if (mem_ready)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        if (mem_stall) begin
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_freeze  = 1'b1;
            ex_mem_freeze = 1'b1;
            mem_wb_freeze = 1'b1;
        end else if (branch_taken) begin
            take_branch = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hazard) begin
            take_hazard  = 1'b1;
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    // Wait counter and sticky timeout; the counter restarts on each entry to MEM_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == RUN && state_next == MEM_WAIT) begin
                wait_cnt <= '0;
            end else if (state == MEM_WAIT) begin
                if (wait_cnt != WAIT_W'(TIMEOUT))
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                if (wait_cnt >= WAIT_W'(TIMEOUT - 1))
                    mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cnt    <= '0;
            mem_stall_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            if (take_hazard && hazard_cnt != '1)
                hazard_cnt <= hazard_cnt + CNT_W'(1);
            if (mem_stall && mem_stall_cnt != '1)
                mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
            if (take_branch && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench with a scoreboard queue of expected
// output vectors and counter values, checked with immediate assertions.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    // {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, mem_wb_freeze}
    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] STALL  = 7'b1101011;
    localparam logic [6:0] FLUSH  = 7'b0010100;
    localparam logic [6:0] BUBBLE = 7'b1100100;

    typedef struct {
        logic [6:0]       outs;
        logic [CNT_W-1:0] hz;
        logic [CNT_W-1:0] ms;
        logic [CNT_W-1:0] fl;
        logic             to;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             fwd_en;
    logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
    logic             id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic             branch_taken, mem_req, mem_ready;
    logic             pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush;
    logic             ex_mem_freeze, mem_wb_freeze, mem_timeout;
    logic [CNT_W-1:0] hazard_cnt, mem_stall_cnt, flush_cnt;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
        .id_ex_freeze(id_ex_freeze), .id_ex_flush(id_ex_flush),
        .ex_mem_freeze(ex_mem_freeze), .mem_wb_freeze(mem_wb_freeze),
        .mem_timeout(mem_timeout), .hazard_cnt(hazard_cnt),
        .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        fwd_en = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_two_src = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Inputs are already driven; push expectations, check outputs mid-cycle,
    // then check counters/timeout just after the edge.
    task automatic cycle(input string tag, input logic [6:0] outs,
                         input int hz, input int ms, input int fl, input logic to);
        exp_t e;
        logic [6:0] obs;
        sb_q.push_back('{outs: outs, hz: CNT_W'(hz), ms: CNT_W'(ms), fl: CNT_W'(fl), to: to});
        @(negedge clk);
        e   = sb_q.pop_front();
        obs = {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
               ex_mem_freeze, mem_wb_freeze};
        tests_run++;
        assert (obs === e.outs) else begin
            tests_failed++;
            $error("FAIL %s outs: got %b expected %b", tag, obs, e.outs);
        end
        @(posedge clk);
        #1;
        tests_run++;
        assert (hazard_cnt === e.hz && mem_stall_cnt === e.ms && flush_cnt === e.fl)
        else begin
            tests_failed++;
            $error("FAIL %s cnt: got hz=%0d ms=%0d fl=%0d expected hz=%0d ms=%0d fl=%0d",
                   tag, hazard_cnt, mem_stall_cnt, flush_cnt, e.hz, e.ms, e.fl);
        end
        tests_run++;
        assert (mem_timeout === e.to) else begin
            tests_failed++;
            $error("FAIL %s timeout: got %b expected %b", tag, mem_timeout, e.to);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        cycle("reset", NONE, 0, 0, 0, 0);

        // Non-forwarding hazard on MEM destination, then forwarding hides it
        fwd_en = 0; id_src1 = 3; id_use_src1 = 1; mem_dest = 3; mem_wb_en = 1;
        cycle("nofwd_mem", BUBBLE, 1, 0, 0, 0);
        fwd_en = 1;
        cycle("fwd_no_load", NONE, 1, 0, 0, 0);
        // Non-forwarding hazard on EXE destination
        fwd_en = 0; mem_wb_en = 0; exe_dest = 3; exe_wb_en = 1;
        cycle("nofwd_exe", BUBBLE, 2, 0, 0, 0);
        clear_inputs();

        // Load-use with forwarding on src2
        fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_two_src = 1; id_src2 = 5;
        cycle("load_use", BUBBLE, 3, 0, 0, 0);
        exe_mem_r_en = 0;
        cycle("load_drop", NONE, 3, 0, 0, 0);
        exe_mem_r_en = 1; id_two_src = 0;
        cycle("load_src2_unused", NONE, 3, 0, 0, 0);
        clear_inputs();

        // Three-cycle memory wait
        mem_req = 1; mem_ready = 0;
        cycle("memw1", STALL, 3, 1, 0, 0);
        cycle("memw2", STALL, 3, 2, 0, 0);
        cycle("memw3", STALL, 3, 3, 0, 0);
        mem_req = 0; mem_ready = 1;
        cycle("mem_ready", NONE, 3, 3, 0, 0);
        mem_ready = 0;
        cycle("idle", NONE, 3, 3, 0, 0);

        // Branch beats hazard
        id_src1 = 3; id_use_src1 = 1; mem_dest = 3; mem_wb_en = 1; branch_taken = 1;
        cycle("branch_hazard", FLUSH, 3, 3, 1, 0);
        // Memory wait beats branch; flush happens on the ready cycle
        mem_req = 1; mem_ready = 0;
        cycle("branch_memw1", STALL, 3, 4, 1, 0);
        cycle("branch_memw2", STALL, 3, 5, 1, 0);
        mem_ready = 1;
        cycle("branch_ready", FLUSH, 3, 5, 2, 0);
        branch_taken = 0; mem_req = 0; mem_ready = 0;
        cycle("hazard_after", BUBBLE, 4, 5, 2, 0);
        clear_inputs();

        // Timeout after 4 MEM_WAIT cycles, sticky until reset
        mem_req = 1; mem_ready = 0;
        cycle("to_run", STALL, 4, 6, 2, 0);
        cycle("to_w1", STALL, 4, 7, 2, 0);
        cycle("to_w2", STALL, 4, 8, 2, 0);
        cycle("to_w3", STALL, 4, 9, 2, 0);
        cycle("to_w4", STALL, 4, 10, 2, 1);
        cycle("to_w5", STALL, 4, 11, 2, 1);
        mem_req = 0; mem_ready = 1;
        cycle("to_ready", NONE, 4, 11, 2, 1);
        mem_ready = 0;
        cycle("to_sticky", NONE, 4, 11, 2, 1);

        // Reset in the middle of a wait
        mem_req = 1;
        cycle("rst_w0", STALL, 4, 12, 2, 1);
        cycle("rst_w1", STALL, 4, 13, 2, 1);
        mem_req = 0; rst = 1;
        cycle("rst_edge", STALL, 0, 0, 0, 0);
        rst = 0;
        cycle("rst_after", NONE, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the bench always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
